// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF input synchroniser, 3-sample majority
// vote per bit, false-start rejection, framing/parity flags and a
// valid/ack output handshake with sticky overrun.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_data,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] Received_byte,
  output logic                 data_valid,
  output logic                 receive_state,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [1:0]           sync;
  logic                 rxs;
  logic [1:0]           hist;
  logic                 vote;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 perr_acc;
  logic                 tick;
  logic                 par_calc;
  logic                 perr_now;

  assign rxs = sync[1];

  // hist[1] = rxs two cycles ago, hist[0] = one cycle ago; with the current
  // rxs this covers instant-1, instant, instant+1 when tick fires.
  assign vote = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);

  // Counter restarts at 0 on entry to START and after every decision, so the
  // first decision lands at t0+CLKS_PER_BIT/2+1 and later ones every bit time.
  assign tick = (state == S_START) ? (cnt == HALF_CNT) : (cnt == FULL_CNT);

  assign par_calc = (^shreg) ^ vote;
  assign perr_now = (PARITY == 1) ? ~par_calc : par_calc;

  // Two-stage synchroniser for the asynchronous RX pin, idles high.
  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[0], RX_data};
  end

  // Short history of the synchronised line for the majority vote.
  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= {hist[0], rxs};
  end

  // Frame FSM, output registers and valid/ack/overrun handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      ferr_acc      <= 1'b0;
      perr_acc      <= 1'b0;
      Received_byte <= '0;
      data_valid    <= 1'b0;
      receive_state <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // Ack clears valid; a DONE in the same cycle overrides this below.
      if (data_ack && data_valid) data_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt           <= '0;
          idx           <= '0;
          ferr_acc      <= 1'b0;
          perr_acc      <= 1'b0;
          // Also drops receive_state one cycle after a rejected start.
          receive_state <= ~rxs;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (tick) begin
            cnt   <= '0;
            state <= vote ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            cnt      <= '0;
            perr_acc <= perr_now;
            state    <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (!vote) ferr_acc <= 1'b1;
            if (idx == LAST_STOP) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          Received_byte <= shreg;
          frame_error   <= ferr_acc;
          parity_error  <= perr_acc;
          data_valid    <= 1'b1;
          // A word acked in this very cycle is not counted as overrun.
          if (data_valid && !data_ack) overrun <= 1'b1;
          receive_state <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg: three instances cover the
// default 8N1 setup, even parity, and a 7-bit / odd parity / 2-stop variant.
module tb_uart_rx_cfg;

  localparam int BIT = 20;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1, rx2;
  logic ack0, ack1, ack2;

  logic [7:0] b0, b1;
  logic [6:0] b2;
  logic dv0, rs0, fe0, pe0, ov0;
  logic dv1, rs1, fe1, pe1, ov1;
  logic dv2, rs2, fe2, pe2, ov2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_rise = -1;
  int rs_rise = -1;
  int rs_fall = -1;
  logic dv_prev = 1'b0;
  logic rs_prev = 1'b0;

  uart_rx_cfg #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .RX_data(rx0), .data_ack(ack0), .Received_byte(b0),
    .data_valid(dv0), .receive_state(rs0), .frame_error(fe0),
    .parity_error(pe0), .overrun(ov0));

  uart_rx_cfg #(.CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .RX_data(rx1), .data_ack(ack1), .Received_byte(b1),
    .data_valid(dv1), .receive_state(rs1), .frame_error(fe1),
    .parity_error(pe1), .overrun(ov1));

  uart_rx_cfg #(.CLKS_PER_BIT(20), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .RX_data(rx2), .data_ack(ack2), .Received_byte(b2),
    .data_valid(dv2), .receive_state(rs2), .frame_error(fe2),
    .parity_error(pe2), .overrun(ov2));

  always #10 clk = ~clk;

  // Edge-time monitor for instance 0: cycle index of valid/busy transitions.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (dv0 && !dv_prev) dv_rise = cyc;
    if (rs0 && !rs_prev) rs_rise = cyc;
    if (!rs0 && rs_prev) rs_fall = cyc;
    dv_prev = dv0;
    rs_prev = rs0;
  end

  task automatic drive(input int which, input logic b);
    case (which)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  // Called 1 ns after a posedge; each frame bit is held BIT cycles, LSB of
  // 'bits' first. 'glitch' inverts the line for one cycle at that offset.
  task automatic send_raw(input int which, input logic [15:0] bits,
                          input int n, input int glitch);
    for (int c = 0; c < n * BIT; c++) begin
      logic b;
      b = bits[c / BIT] ^ (c == glitch);
      drive(which, b);
      @(posedge clk); #1;
    end
    drive(which, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    checks++;
    if (b0 !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", b0); end
    checks++;
    if ({dv0, rs0, fe0, pe0, ov0, dv1, rs1, dv2, rs2} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000000",
               {dv0, rs0, fe0, pe0, ov0, dv1, rs1, dv2, rs2});
    end
  endtask

  task automatic test_frame_55;
    int p;
    dv_rise = -1; rs_rise = -1; rs_fall = -1;
    p = cyc;
    send_raw(0, 16'({1'b1, 8'h55, 1'b0}), 10, -1);
    checks++;
    if (b0 !== 8'h55) begin errors++; $display("FAIL f55_byte got %h exp 55", b0); end
    checks++;
    if ({dv0, fe0, pe0} !== 3'b100) begin
      errors++; $display("FAIL f55_flags dv/fe/pe got %b exp 100", {dv0, fe0, pe0});
    end
    // pin low at cycle p -> rxs seen by FSM at p+3 (t0); last stop instant
    // t0+10+9*20, vote one cycle later, DONE register one more.
    checks++;
    if (rs_rise - p !== 3) begin errors++; $display("FAIL f55_rs_rise got %0d exp 3", rs_rise - p); end
    checks++;
    if (dv_rise - p !== 195) begin errors++; $display("FAIL f55_dv_rise got %0d exp 195", dv_rise - p); end
    checks++;
    if (rs_fall - p !== 195) begin errors++; $display("FAIL f55_rs_fall got %0d exp 195", rs_fall - p); end
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    checks++;
    if (dv0 !== 1'b0) begin errors++; $display("FAIL f55_ack dv got %b exp 0", dv0); end
  endtask

  task automatic test_parity;
    send_raw(1, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, -1);
    checks++;
    if (b1 !== 8'hA5) begin errors++; $display("FAIL par_bad_byte got %h exp a5", b1); end
    checks++;
    if ({dv1, pe1, fe1} !== 3'b110) begin
      errors++; $display("FAIL par_bad_flags dv/pe/fe got %b exp 110", {dv1, pe1, fe1});
    end
    ack1 = 1'b1; step(1); ack1 = 1'b0;
    step(5);
    send_raw(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, -1);
    checks++;
    if (b1 !== 8'hA5) begin errors++; $display("FAIL par_ok_byte got %h exp a5", b1); end
    checks++;
    if ({dv1, pe1, fe1, ov1} !== 4'b1000) begin
      errors++; $display("FAIL par_ok_flags dv/pe/fe/ov got %b exp 1000", {dv1, pe1, fe1, ov1});
    end
    ack1 = 1'b1; step(1); ack1 = 1'b0;
  endtask

  task automatic test_frame_error;
    send_raw(0, 16'({1'b0, 8'h3C, 1'b0}), 10, -1);
    checks++;
    if (b0 !== 8'h3C) begin errors++; $display("FAIL ferr_byte got %h exp 3c", b0); end
    checks++;
    if ({dv0, fe0} !== 2'b11) begin errors++; $display("FAIL ferr_flag dv/fe got %b exp 11", {dv0, fe0}); end
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    step(40);
    send_raw(0, 16'({1'b1, 8'h81, 1'b0}), 10, -1);
    checks++;
    if (b0 !== 8'h81) begin errors++; $display("FAIL resync_byte got %h exp 81", b0); end
    checks++;
    if ({dv0, fe0, pe0, ov0} !== 4'b1000) begin
      errors++; $display("FAIL resync_flags dv/fe/pe/ov got %b exp 1000", {dv0, fe0, pe0, ov0});
    end
  endtask

  task automatic test_glitch;
    int p;
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    step(5);
    rs_rise = -1; rs_fall = -1;
    p = cyc;
    rx0 = 1'b0;
    step(5);
    rx0 = 1'b1;
    step(40);
    checks++;
    if (rs_rise - p !== 3) begin errors++; $display("FAIL glitch_rs_rise got %0d exp 3", rs_rise - p); end
    checks++;
    if (rs_fall - p !== 15) begin errors++; $display("FAIL glitch_rs_fall got %0d exp 15", rs_fall - p); end
    checks++;
    if ({dv0, rs0} !== 2'b00) begin errors++; $display("FAIL glitch_idle dv/rs got %b exp 00", {dv0, rs0}); end
  endtask

  task automatic test_vote_glitch;
    // One-cycle inversion at the centre of data bit 3 (frame bit 4).
    send_raw(0, 16'({1'b1, 8'h96, 1'b0}), 10, 4 * BIT + 10);
    checks++;
    if (b0 !== 8'h96) begin errors++; $display("FAIL vote_byte got %h exp 96", b0); end
    checks++;
    if ({dv0, fe0} !== 2'b10) begin errors++; $display("FAIL vote_flags dv/fe got %b exp 10", {dv0, fe0}); end
  endtask

  task automatic test_back_to_back;
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    step(5);
    send_raw(0, 16'({1'b1, 8'h12, 1'b0}), 10, -1);
    send_raw(0, 16'({1'b1, 8'h34, 1'b0}), 10, -1);
    checks++;
    if (b0 !== 8'h34) begin errors++; $display("FAIL b2b_byte got %h exp 34", b0); end
    checks++;
    if ({dv0, ov0} !== 2'b11) begin errors++; $display("FAIL b2b_overrun dv/ov got %b exp 11", {dv0, ov0}); end
    ack0 = 1'b1; step(1); ack0 = 1'b0;
    checks++;
    if ({dv0, ov0} !== 2'b01) begin errors++; $display("FAIL b2b_ack dv/ov got %b exp 01", {dv0, ov0}); end
    step(10);
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL b2b_sticky ov got %b exp 1", ov0); end
  endtask

  task automatic test_rst_mid;
    // Start bit plus four data bits of 0xFF, then reset mid-DATA.
    send_raw(0, 16'({4'hF, 1'b0}), 5, -1);
    rst = 1'b1; step(1); rst = 1'b0;
    checks++;
    if (b0 !== 8'h00) begin errors++; $display("FAIL rst_byte got %h exp 00", b0); end
    checks++;
    if ({dv0, rs0, fe0, pe0, ov0} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 00000", {dv0, rs0, fe0, pe0, ov0});
    end
    step(5);
    send_raw(0, 16'({1'b1, 8'h0F, 1'b0}), 10, -1);
    checks++;
    if (b0 !== 8'h0F) begin errors++; $display("FAIL rst_next_byte got %h exp 0f", b0); end
    checks++;
    if ({dv0, fe0, ov0} !== 3'b100) begin
      errors++; $display("FAIL rst_next_flags dv/fe/ov got %b exp 100", {dv0, fe0, ov0});
    end
  endtask

  task automatic test_cfg7;
    // start, 7 data LSB first, odd parity 1, stop1 high, stop2 low.
    send_raw(2, 16'({1'b0, 1'b1, 1'b1, 7'h41, 1'b0}), 11, -1);
    checks++;
    if (b2 !== 7'h41) begin errors++; $display("FAIL cfg7_byte got %h exp 41", b2); end
    checks++;
    if ({dv2, fe2, pe2, ov2} !== 4'b1100) begin
      errors++; $display("FAIL cfg7_flags dv/fe/pe/ov got %b exp 1100", {dv2, fe2, pe2, ov2});
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_frame_55;
    test_parity;
    test_frame_error;
    test_glitch;
    test_vote_glitch;
    test_back_to_back;
    test_rst_mid;
    test_cfg7;
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
